// File: rtl/imem_if.sv
// imem_if: instruction-memory request (valid/ready) and response (valid-only) bundle
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: pc, imem requests, output+skid buffering; FETCH_ALIGN_CHECK_EN adds misaligned-redirect FAULT
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_stall,
    input  logic        e_pc_src,
    input  logic [31:0] e_pc_target,
    imem_if.master      imem,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc_plus_4,
    output logic [31:0] f_instruction,
    output logic        f_fault
);
    logic [31:0]      pc, skid_pc, skid_instr, target;
    logic             skid_valid, rsp, keep, acc, consume, fault;
    logic [1:0][31:0] q_addr, n_addr;
    logic [1:0]       q_drop, n_drop, q_cnt, n_cnt;
    logic [2:0]       load;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic {RUN, FAULT} state_t;
    state_t state;
    assign fault  = state == FAULT;
    assign target = e_pc_target;
`else
    assign fault  = 1'b0;
    assign target = e_pc_target & ~32'h3;
`endif

    assign f_fault   = fault;
    assign rsp       = imem.rvalid && q_cnt != 2'd0;
    assign keep      = rsp && !q_drop[0];
    assign consume   = f_valid && !f_stall;
    assign load      = {2'b0, f_valid} + {2'b0, skid_valid} + {1'b0, q_cnt};
    assign imem.req  = reset && !e_pc_src && !fault && load < (consume ? 3'd3 : 3'd2);
    assign imem.addr = pc;
    assign acc       = imem.req && imem.ready;

    // In-order address queue: pop on response, push on acceptance, mark everything drop on redirect
    always_comb begin
        n_addr = q_addr;
        n_drop = q_drop;
        n_cnt  = q_cnt;
        if (rsp) begin
            n_addr[0] = q_addr[1];
            n_drop[0] = q_drop[1];
            n_cnt     = q_cnt - 2'd1;
        end
        if (acc) begin
            n_addr[n_cnt[0]] = pc;
            n_drop[n_cnt[0]] = 1'b0;
            n_cnt            = n_cnt + 2'd1;
        end
        if (e_pc_src) n_drop = 2'b11;
    end

    // Pipeline state: pc, output register, skid register, queue and fault state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_PC;
            f_valid       <= 1'b0;
            f_pc          <= '0;
            f_pc_plus_4   <= '0;
            f_instruction <= '0;
            skid_valid    <= 1'b0;
            skid_pc       <= '0;
            skid_instr    <= '0;
            q_addr        <= '0;
            q_drop        <= '0;
            q_cnt         <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            state         <= RUN;
`endif
        end else begin
            q_addr <= n_addr;
            q_drop <= n_drop;
            q_cnt  <= n_cnt;
            if (e_pc_src) begin
                pc         <= target;
                f_valid    <= 1'b0;
                skid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                state       <= |e_pc_target[1:0] ? FAULT : RUN;
                f_pc        <= e_pc_target;
                f_pc_plus_4 <= e_pc_target + 32'd4;
`endif
            end else begin
                if (acc) pc <= pc + 32'd4;
                if (!f_valid || consume) begin
                    if (skid_valid) begin
                        f_valid       <= 1'b1;
                        f_pc          <= skid_pc;
                        f_pc_plus_4   <= skid_pc + 32'd4;
                        f_instruction <= skid_instr;
                    end else if (keep) begin
                        f_valid       <= 1'b1;
                        f_pc          <= q_addr[0];
                        f_pc_plus_4   <= q_addr[0] + 32'd4;
                        f_instruction <= imem.rdata;
                    end else begin
                        f_valid <= 1'b0;
                    end
                end
                skid_valid <= (!f_valid || consume) ? (skid_valid && keep) : (skid_valid || keep);
                if (keep) begin
                    skid_pc    <= q_addr[0];
                    skid_instr <= imem.rdata;
                end
            end
        end
    end
endmodule
